// File: rtl/bpi_image_selector_pkg.sv
// Shared definitions for the BPI multiboot image selector: FSM state
// encoding, BPI mode-pin decode and counter sizing.
package bpi_image_selector_pkg;

   localparam int PAGE_W = 5;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_PROG      = 3'd1,
      ST_WAIT_INIT = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   // Mode pins ordered {m2, m1, m0}; BPI when m1=1 and m2=0, m0 is don't-care.
   localparam logic [2:0] BPI_MODE_MASK = 3'b110;
   localparam logic [2:0] BPI_MODE_VAL  = 3'b010;

   // Width that holds every count value up to the larger timeout limit.
   function automatic int cnt_width(input int init_to, input int done_to);
      int m;
      m = (init_to > done_to) ? init_to : done_to;
      return $clog2(m + 1);
   endfunction

   function automatic logic is_bpi(input logic m2, input logic m1, input logic m0);
      return (({m2, m1, m0} & BPI_MODE_MASK) == BPI_MODE_VAL);
   endfunction

endpackage

// File: rtl/bpi_image_selector_if.sv
// Pin bundle between user logic / FPGA pins and the image selector.
interface bpi_image_selector_if;
   import bpi_image_selector_pkg::*;

   logic              m0;
   logic              m1;
   logic              m2;
   logic              DONE;
   logic              INIT_B;
   logic              SEL_VALID;
   logic [PAGE_W-1:0] SEL_PAGE;
   logic              SEL_READY;
   logic              PROG_B;
   logic              A_OE;
   logic [PAGE_W-1:0] A_PAGE;
   logic              BUSY;
   logic              ERR;

   modport master (
      output m0, m1, m2, DONE, INIT_B, SEL_VALID, SEL_PAGE,
      input  SEL_READY, PROG_B, A_OE, A_PAGE, BUSY, ERR
   );

   modport slave (
      input  m0, m1, m2, DONE, INIT_B, SEL_VALID, SEL_PAGE,
      output SEL_READY, PROG_B, A_OE, A_PAGE, BUSY, ERR
   );

endinterface

// File: rtl/bpi_image_selector_sync2.sv
// Two-flop resynchronizer for the asynchronous FPGA status pins.
module bpi_image_selector_sync2 (
   input  logic CLK,
   input  logic RST_B,
   input  logic d,
   output logic q
);

   logic meta;

   // Two register stages; both flush to 0 on reset.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/bpi_image_selector.sv
// Multiboot image selector: accepts a flash page request once the FPGA is
// configured, drives it onto A[24:20], pulses PROG_B and supervises
// INIT_B/DONE, retrying once from the golden page before giving up.
module bpi_image_selector
   import bpi_image_selector_pkg::*;
#(
   parameter int                PROG_CYC     = 8,
   parameter int                INIT_TO      = 4096,
   parameter int                DONE_TO      = 1048576,
   parameter logic [PAGE_W-1:0] DEFAULT_PAGE = 5'b00000
) (
   input logic                 CLK,
   input logic                 RST_B,
   bpi_image_selector_if.slave bus
);

   localparam int               CNT_W     = cnt_width(INIT_TO, DONE_TO);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   // Limits are compared against count == limit-1, i.e. limit cycles in state.
   localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYC - 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TO - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TO - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [PAGE_W-1:0] page;
   logic [PAGE_W-1:0] page_nxt;
   logic              fallback;
   logic              fallback_nxt;
   logic              err;
   logic              err_nxt;
   logic              timeout;

   logic              done_s;
   logic              init_s;
   logic              bpi;
   logic              handshake;

   logic              prog_b;
   logic              prog_b_nxt;
   logic              a_oe;
   logic              a_oe_nxt;
   logic              busy;
   logic              busy_nxt;
   logic              sel_ready;
   logic              sel_ready_nxt;

   bpi_image_selector_sync2 u_sync_done (
      .CLK   (CLK),
      .RST_B (RST_B),
      .d     (bus.DONE),
      .q     (done_s)
   );

   bpi_image_selector_sync2 u_sync_init (
      .CLK   (CLK),
      .RST_B (RST_B),
      .d     (bus.INIT_B),
      .q     (init_s)
   );

   // Mode straps are static board pins, so they are used unsynchronized.
   assign bpi       = is_bpi(bus.m2, bus.m1, bus.m0);
   assign handshake = bus.SEL_VALID & sel_ready;

   // State, page, fallback flag and sticky error registers.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         state    <= ST_RUN;
         page     <= DEFAULT_PAGE;
         fallback <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         page     <= page_nxt;
         fallback <= fallback_nxt;
         err      <= err_nxt;
      end
   end

   // Next-state decision; a lost BPI mode outranks every other event.
   always_comb begin
      state_nxt    = state;
      page_nxt     = page;
      fallback_nxt = fallback;
      err_nxt      = err;
      timeout      = 1'b0;
      case (state)
         ST_RUN: begin
            if (handshake) begin
               page_nxt     = bus.SEL_PAGE;
               fallback_nxt = 1'b0;
               state_nxt    = ST_PROG;
            end
         end
         ST_PROG: begin
            if (!bpi) begin
               state_nxt = ST_RUN;
            end else if (cnt == PROG_LAST) begin
               state_nxt = ST_WAIT_INIT;
            end
         end
         ST_WAIT_INIT: begin
            // DONE is deliberately ignored here; INIT_B has to rise first.
            if (!bpi) begin
               state_nxt = ST_RUN;
            end else if (init_s) begin
               state_nxt = ST_WAIT_DONE;
            end else if (cnt == INIT_LAST) begin
               timeout = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!bpi) begin
               state_nxt = ST_RUN;
            end else if (done_s) begin
               fallback_nxt = 1'b0;
               state_nxt    = ST_RUN;
            end else if (cnt == DONE_LAST) begin
               timeout = 1'b1;
            end
         end
         ST_FAIL: begin
            state_nxt = ST_FAIL;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
      // First failure retries from the golden page; a failed retry is fatal.
      if (timeout) begin
         if (fallback) begin
            err_nxt   = 1'b1;
            state_nxt = ST_FAIL;
         end else begin
            page_nxt     = DEFAULT_PAGE;
            fallback_nxt = 1'b1;
            state_nxt    = ST_PROG;
         end
      end
   end

   // Shared phase counter: zero on every state entry, idle outside timed states.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         cnt <= '0;
      end else if ((state_nxt != state) || (state == ST_RUN) || (state == ST_FAIL)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Output decode from the upcoming state so the pins change on the same edge.
   always_comb begin
      prog_b_nxt    = 1'b1;
      a_oe_nxt      = 1'b0;
      busy_nxt      = 1'b0;
      sel_ready_nxt = (state_nxt == ST_RUN) && done_s && bpi;
      case (state_nxt)
         ST_PROG: begin
            prog_b_nxt = 1'b0;
            a_oe_nxt   = 1'b1;
            busy_nxt   = 1'b1;
         end
         ST_WAIT_INIT, ST_WAIT_DONE: begin
            a_oe_nxt = 1'b1;
            busy_nxt = 1'b1;
         end
         default: begin
            prog_b_nxt = 1'b1;
         end
      endcase
   end

   // Registered pin drivers keep PROG_B and A_OE glitch-free.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         prog_b    <= 1'b1;
         a_oe      <= 1'b0;
         busy      <= 1'b0;
         sel_ready <= 1'b0;
      end else begin
         prog_b    <= prog_b_nxt;
         a_oe      <= a_oe_nxt;
         busy      <= busy_nxt;
         sel_ready <= sel_ready_nxt;
      end
   end

   assign bus.PROG_B    = prog_b;
   assign bus.A_OE      = a_oe;
   assign bus.A_PAGE    = page;
   assign bus.BUSY      = busy;
   assign bus.SEL_READY = sel_ready;
   assign bus.ERR       = err;

endmodule
